qed_dup_sequencer: RTL and testbench



---
 rtl/qed_seq_pkg.sv | 33 +++
 rtl/qed_modify_ins.sv | 59 +++++
 rtl/qed_dup_sequencer.sv | 111 +++++++++++
 tb/tb_qed_dup_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qed_seq_pkg.sv
// Shared opcodes, sequencer state and instruction field layout for the QED duplication front end.
package qed_seq_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   typedef enum logic {
      ORIG  = 1'b0,
      DRAIN = 1'b1
   } seq_state_t;

   // R-type view; other formats reuse the same bit positions for their immediates.
   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } rv_instr_t;

   function automatic logic is_dup_class(input logic [6:0] op);
      case (op)
         OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC: return 1'b1;
         default:                                            return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/qed_modify_ins.sv
// Rewrites a duplicable instruction onto the shadow register half and shadow memory partition.
// Purely combinational; x0 operands are left untouched.
module qed_modify_ins
   import qed_seq_pkg::*;
#(
   parameter int REG_ADDR_W   = 5,
   parameter int MEM_PART_BIT = 6
) (
   input  logic [31:0] instr,
   output logic [31:0] instr_mod
);

   function automatic logic [REG_ADDR_W-1:0] shadow_reg(input logic [REG_ADDR_W-1:0] r);
      return (r == '0) ? '0 : {1'b1, r[REG_ADDR_W-2:0]};
   endfunction

   function automatic logic [11:0] shadow_imm(input logic [11:0] imm);
      logic [11:0] part_bit;
      part_bit = 12'd1 << MEM_PART_BIT;
      return part_bit | (imm & (part_bit - 12'd1));
   endfunction

   rv_instr_t in_f;
   rv_instr_t out_f;

   assign in_f      = instr;
   assign instr_mod = out_f;

   always_comb begin
      out_f = in_f;
      case (in_f.opcode)
         OP_R: begin
            out_f.rd  = shadow_reg(in_f.rd);
            out_f.rs1 = shadow_reg(in_f.rs1);
            out_f.rs2 = shadow_reg(in_f.rs2);
         end
         OP_IALU: begin
            out_f.rd  = shadow_reg(in_f.rd);
            out_f.rs1 = shadow_reg(in_f.rs1);
         end
         OP_LOAD: begin
            out_f.rd                   = shadow_reg(in_f.rd);
            out_f.rs1                  = shadow_reg(in_f.rs1);
            {out_f.funct7, out_f.rs2}  = shadow_imm({in_f.funct7, in_f.rs2});
         end
         // STORE offset is split across funct7 and rd positions
         OP_STORE: begin
            out_f.rs1                  = shadow_reg(in_f.rs1);
            out_f.rs2                  = shadow_reg(in_f.rs2);
            {out_f.funct7, out_f.rd}   = shadow_imm({in_f.funct7, in_f.rd});
         end
         OP_LUI, OP_AUIPC: begin
            out_f.rd = shadow_reg(in_f.rd);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/qed_dup_sequencer.sv
// EDDI-V sequencer: forwards originals, queues duplicables and re-issues them as shadow duplicates.
// One-cycle output register; valid/ready on both sides, input held off while draining.
module qed_dup_sequencer
   import qed_seq_pkg::*;
#(
   parameter int ILEN         = 32,
   parameter int REG_ADDR_W   = 5,
   parameter int MEM_PART_BIT = 6,
   parameter int DEPTH        = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mode,
   input  logic                     exec_dup,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ILEN-1:0]          in_instr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ILEN-1:0]          out_instr,
   output logic                     out_is_dup,
   output logic [$clog2(DEPTH):0]   pending
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [ILEN-1:0] queue_mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [PW-1:0]   count;
   seq_state_t      state;
   logic            mode_q;

   logic            in_sync;
   logic            out_loadable;
   logic            overflow;
   logic            sync_block;
   logic            accept;
   logic            push;
   logic            pop;
   logic            go_drain;
   logic [ILEN-1:0] head_mod;

   assign in_sync      = !is_dup_class(in_instr[6:0]);
   assign out_loadable = !out_valid || out_ready;
   assign overflow     = mode_q && !in_sync && (count == PW'(DEPTH));
   assign sync_block   = in_sync && (count != '0);
   assign in_ready     = (state == ORIG) && out_loadable && !overflow && !sync_block;
   assign accept       = in_valid && in_ready;
   assign push         = accept && mode_q && !in_sync;
   assign pop          = (state == DRAIN) && out_loadable;
   assign pending      = count;

   // A blocked sync instruction forces the drain so it never waits behind stale entries.
   assign go_drain = (push && (count == PW'(DEPTH - 1)))
                   || (exec_dup && (count != '0))
                   || (in_valid && in_sync && (count != '0));

   qed_modify_ins #(
      .REG_ADDR_W   (REG_ADDR_W),
      .MEM_PART_BIT (MEM_PART_BIT)
   ) u_modify (
      .instr     (queue_mem[rd_ptr]),
      .instr_mod (head_mod)
   );

   always_ff @(posedge clk) begin
      if (push) queue_mem[wr_ptr] <= in_instr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ORIG;
         mode_q     <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         out_valid  <= 1'b0;
         out_instr  <= '0;
         out_is_dup <= 1'b0;
      end else begin
         // Mode only switches with an empty queue, so no entry is ever stranded.
         if ((state == ORIG) && (count == '0)) mode_q <= mode;

         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);

         if (push)     count <= count + PW'(1);
         else if (pop) count <= count - PW'(1);

         case (state)
            ORIG:  if (go_drain) state <= DRAIN;
            DRAIN: if (pop && (count == PW'(1))) state <= ORIG;
            default: state <= ORIG;
         endcase

         if (out_loadable) begin
            out_valid <= accept || pop;
            if (pop) begin
               out_instr  <= head_mod;
               out_is_dup <= 1'b1;
            end else if (accept) begin
               out_instr  <= in_instr;
               out_is_dup <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Directed and randomized bench for qed_dup_sequencer against an ordered-stream reference model.
module tb_qed_dup_sequencer;

   localparam int DEPTH = 4;
   localparam int MPB   = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mode = 1'b0;
   logic        exec_dup = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_is_dup;
   logic [2:0]  pending;

   logic dir_ready = 1'b1;
   logic rnd_en    = 1'b0;
   logic rnd_bit   = 1'b1;
   assign out_ready = rnd_en ? rnd_bit : dir_ready;

   int total = 0;
   int bad   = 0;

   logic [32:0] exp_q[$];
   logic [31:0] mq[$];
   logic        model_mode = 1'b0;
   logic [31:0] last_instr = '0;
   logic        last_dup   = 1'b0;
   logic        stall_prev = 1'b0;
   logic [32:0] held      = '0;

   qed_dup_sequencer #(
      .ILEN(32), .REG_ADDR_W(5), .MEM_PART_BIT(MPB), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .exec_dup(exec_dup),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_is_dup(out_is_dup), .pending(pending)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      #1;
      rnd_bit = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #800000;
      $display("FAIL watchdog: got no finish want finish before timeout");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, expv);
      end
   endtask

   // Reference: shadow register = 16 + (r mod 16), shadow partition = 2^MPB + (imm mod 2^MPB).
   function automatic int sh_reg(input int r);
      return (r == 0) ? 0 : 16 + (r % 16);
   endfunction

   function automatic int sh_imm(input int imm);
      return (1 << MPB) + (imm % (1 << MPB));
   endfunction

   function automatic logic [31:0] ref_mod(input logic [31:0] i);
      int op, rd, f3, rs1, rs2, f7, imm;
      op = int'(i[6:0]);   rd  = int'(i[11:7]);  f3 = int'(i[14:12]);
      rs1 = int'(i[19:15]); rs2 = int'(i[24:20]); f7 = int'(i[31:25]);
      case (op)
         'h33: begin rd = sh_reg(rd); rs1 = sh_reg(rs1); rs2 = sh_reg(rs2); end
         'h13: begin rd = sh_reg(rd); rs1 = sh_reg(rs1); end
         'h03: begin
            rd = sh_reg(rd); rs1 = sh_reg(rs1);
            imm = sh_imm(f7 * 32 + rs2); f7 = imm / 32; rs2 = imm % 32;
         end
         'h23: begin
            rs1 = sh_reg(rs1); rs2 = sh_reg(rs2);
            imm = sh_imm(f7 * 32 + rd); f7 = imm / 32; rd = imm % 32;
         end
         'h37, 'h17: rd = sh_reg(rd);
         default: ;
      endcase
      return 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op);
   endfunction

   function automatic bit ref_dup(input logic [31:0] i);
      return int'(i[6:0]) inside {'h33, 'h13, 'h03, 'h23, 'h37, 'h17};
   endfunction

   task automatic flush_model();
      while (mq.size() > 0) exp_q.push_back({1'b1, ref_mod(mq.pop_front())});
   endtask

   task automatic model_in(input logic [31:0] ins);
      if (!model_mode) begin
         exp_q.push_back({1'b0, ins});
      end else if (ref_dup(ins)) begin
         exp_q.push_back({1'b0, ins});
         mq.push_back(ins);
         if (mq.size() == DEPTH) flush_model();
      end else begin
         flush_model();
         exp_q.push_back({1'b0, ins});
      end
   endtask

   // Output monitor: scoreboard on every handshake, stability check under backpressure.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("hold_instr", out_instr, held[31:0]);
            chk("hold_dup", {31'b0, out_is_dup}, {31'b0, held[32]});
         end
         if (out_valid && out_ready) begin
            last_instr = out_instr;
            last_dup   = out_is_dup;
            total++;
            assert (exp_q.size() > 0) else begin
               bad++;
               $error("FAIL unexpected_out: got %h want no output", out_instr);
            end
            if (exp_q.size() > 0) begin
               held = exp_q.pop_front();
               chk("sb_instr", out_instr, held[31:0]);
               chk("sb_dup", {31'b0, out_is_dup}, {31'b0, held[32]});
            end
         end
         stall_prev = out_valid && !out_ready;
         held       = {out_is_dup, out_instr};
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_raw(input logic [31:0] ins);
      bit done;
      done     = 1'b0;
      in_instr = ins;
      in_valid = 1'b1;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         step();
      end
      in_valid = 1'b0;
      total++;
      assert (done) else begin
         bad++;
         $error("FAIL send_timeout: got no accept want accept of %h", ins);
      end
   endtask

   task automatic send(input logic [31:0] ins);
      model_in(ins);
      send_raw(ins);
   endtask

   task automatic drain_wait();
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < 400) begin
         step();
         c++;
      end
      total++;
      assert (exp_q.size() == 0) else begin
         bad++;
         $error("FAIL drain_timeout: got %0d outstanding want 0", exp_q.size());
      end
      step();
   endtask

   task automatic pulse_exec();
      if (mq.size() > 0) flush_model();
      exec_dup = 1'b1;
      step();
      exec_dup = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] v;
      logic [6:0]  ops [9];
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6f, 7'h73};
      v = $urandom;
      v[6:0] = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 3) == 0) v[19:15] = 5'd0;
      if ($urandom_range(0, 3) == 0) v[11:7]  = 5'd0;
      return v;
   endfunction

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_is_dup", {31'b0, out_is_dup}, 32'd0);
      chk("rst_pending", {29'b0, pending}, 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // OFF passthrough
      send(32'h003100B3);
      @(negedge clk);
      chk("off_valid", {31'b0, out_valid}, 32'd1);
      chk("off_instr", out_instr, 32'h003100B3);
      chk("off_dup", {31'b0, out_is_dup}, 32'd0);
      chk("off_pending", {29'b0, pending}, 32'd0);
      step();

      // Full-queue drain
      mode = 1'b1; model_mode = 1'b1;
      step(); step();
      repeat (4) send(32'h00510093);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("full_pending", {29'b0, pending}, 32'(4 - k));
         chk("full_in_ready", {31'b0, in_ready}, (k < 4) ? 32'd0 : 32'd1);
         if (k >= 1) begin
            chk("full_dup_instr", out_instr, 32'h00590893);
            chk("full_dup_flag", {31'b0, out_is_dup}, 32'd1);
         end
      end
      step();
      drain_wait();

      // x0, LOAD partition, STORE split
      send(32'h00000013); pulse_exec(); drain_wait();
      chk("x0_dup", last_instr, 32'h00000013);
      chk("x0_flag", {31'b0, last_dup}, 32'd1);
      send(32'h00812083); pulse_exec(); drain_wait();
      chk("load_dup", last_instr, 32'h04892883);
      send(32'h00312423); pulse_exec(); drain_wait();
      chk("store_dup", last_instr, 32'h05392423);

      // Sync point holds off BEQ until the queue empties
      send(32'h002081B3);
      send(32'h002081B3);
      in_instr = 32'h00208463;
      in_valid = 1'b1;
      model_in(32'h00208463);
      @(negedge clk);
      chk("sync_in_ready", {31'b0, in_ready}, 32'd0);
      chk("sync_pending", {29'b0, pending}, 32'd2);
      send_raw(32'h00208463);
      drain_wait();
      chk("sync_last", last_instr, 32'h00208463);
      chk("sync_last_flag", {31'b0, last_dup}, 32'd0);
      chk("sync_pending_end", {29'b0, pending}, 32'd0);

      // Backpressure mid-drain with a mode toggle
      for (int k = 0; k < 4; k++) send(32'h00510093 | (32'(k + 1) << 7));
      step();
      dir_ready = 1'b0;
      mode = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_instr", out_instr, 32'h00590893);
         chk("bp_flag", {31'b0, out_is_dup}, 32'd1);
         chk("bp_pending", {29'b0, pending}, 32'd3);
      end
      step();
      model_mode = 1'b0;
      dir_ready = 1'b1;
      drain_wait();
      chk("bp_pending_end", {29'b0, pending}, 32'd0);
      send(32'h00A00113);
      @(negedge clk);
      chk("mode_off_pending", {29'b0, pending}, 32'd0);
      chk("mode_off_flag", {31'b0, out_is_dup}, 32'd0);
      step();
      drain_wait();

      // Reset mid-drain
      mode = 1'b1; model_mode = 1'b1;
      step(); step();
      repeat (4) send(32'h00510093);
      step();
      dir_ready = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      mq.delete();
      @(negedge clk);
      chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      chk("mid_rst_pending", {29'b0, pending}, 32'd0);
      chk("mid_rst_instr", out_instr, 32'd0);
      step();
      rst_n = 1'b1;
      dir_ready = 1'b1;
      step(); step();
      @(negedge clk);
      chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
      step();

      // Randomized traffic with random backpressure
      rnd_en = 1'b1;
      for (int it = 0; it < 250; it++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 8) begin
            drain_wait(); pulse_exec(); drain_wait();
         end else if (r < 11) begin
            drain_wait(); pulse_exec(); drain_wait();
            mode = ~mode; model_mode = mode;
            step(); step();
         end else begin
            send(rand_instr());
            if ($urandom_range(0, 3) == 0) step();
         end
      end
      drain_wait(); pulse_exec(); drain_wait();
      rnd_en = 1'b0;
      chk("final_pending", {29'b0, pending}, 32'd0);
      chk("final_outstanding", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
